// File: rtl/axi_tb_ctrl_slave_if.sv
// AXI4-Lite bundle between a bench master and the testbench control slave.
// Signal suffixes are given from the slave's point of view.
interface axi_tb_ctrl_slave_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  awvalid_i;
   logic                  awready_o;
   logic [ADDR_WIDTH-1:0] awaddr_i;
   logic                  wvalid_i;
   logic                  wready_o;
   logic [31:0]           wdata_i;
   logic [3:0]            wstrb_i;
   logic                  bvalid_o;
   logic                  bready_i;
   logic [1:0]            bresp_o;
   logic                  arvalid_i;
   logic                  arready_o;
   logic [ADDR_WIDTH-1:0] araddr_i;
   logic                  rvalid_o;
   logic                  rready_i;
   logic [31:0]           rdata_o;
   logic [1:0]            rresp_o;

   modport slave (
      input  awvalid_i, awaddr_i, wvalid_i, wdata_i, wstrb_i, bready_i,
             arvalid_i, araddr_i, rready_i,
      output awready_o, wready_o, bvalid_o, bresp_o, arready_o, rvalid_o, rdata_o, rresp_o
   );

   modport master (
      output awvalid_i, awaddr_i, wvalid_i, wdata_i, wstrb_i, bready_i,
             arvalid_i, araddr_i, rready_i,
      input  awready_o, wready_o, bvalid_o, bresp_o, arready_o, rvalid_o, rdata_o, rresp_o
   );
endinterface

// File: rtl/axi_tb_ctrl_slave.sv
// Testbench control slave: a 16-byte AXI4-Lite register window giving a
// program under test a stdout byte port (PRINT), an exit code (EXIT), a
// pass/fail flag (STATUS) and an optional cycle counter (CYCLES).
// Optional feature macro: TB_CTRL_CYCLE_COUNTER_EN enables the CYCLES counter.
module axi_tb_ctrl_slave #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h2000_0000
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   axi_tb_ctrl_slave_if.slave        bus,
   output logic                      print_valid_o,
   output logic [31:0]               print_wdata_o,
   output logic                      tests_passed_o,
   output logic                      tests_failed_o,
   output logic                      exit_valid_o,
   output logic [31:0]               exit_value_o
);

   localparam logic [1:0]  RespOkay   = 2'b00;
   localparam logic [1:0]  RespSlverr = 2'b10;
   localparam logic [1:0]  RespDecerr = 2'b11;
   localparam logic [31:0] PassMagic  = 32'd123456789;
   localparam logic [31:0] FailMagic  = 32'd1;

   typedef enum logic [1:0] {StIdle, StHaveAw, StHaveW, StResp} wr_state_e;
   typedef enum logic {RdIdle, RdResp} rd_state_e;

   wr_state_e             wr_state_q;
   rd_state_e             rd_state_q;

   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wstrb_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;

   logic                  print_valid_q;
   logic [31:0]           print_wdata_q;
   logic                  exit_valid_q;
   logic [31:0]           exit_value_q;
   logic                  passed_q;
   logic                  failed_q;

   logic                  rvalid_q;
   logic [31:0]           rdata_q;
   logic [1:0]            rresp_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic                  wr_commit;

   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [31:0]           wr_data;
   logic [3:0]            wr_strb;
   logic [ADDR_WIDTH-1:0] wr_off;
   logic [1:0]            wr_resp;
   logic                  do_print;
   logic                  do_exit;
   logic                  do_pass;
   logic                  do_fail;

   logic [ADDR_WIDTH-1:0] rd_off;
   logic [31:0]           rd_data;
   logic [1:0]            rd_resp;

`ifdef TB_CTRL_CYCLE_COUNTER_EN
   logic [31:0]           cycle_q;

   // Free-running cycle counter, wraps naturally at 2^32.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
      end
   end
`endif

   // Readies are decoded from the FSM state and gated by reset so they are low
   // during reset yet high in the very first cycle after release.
   assign bus.awready_o = rst_ni & ((wr_state_q == StIdle) | (wr_state_q == StHaveW));
   assign bus.wready_o  = rst_ni & ((wr_state_q == StIdle) | (wr_state_q == StHaveAw));
   assign bus.arready_o = rst_ni & (rd_state_q == RdIdle);

   assign aw_hs = bus.awvalid_i & bus.awready_o;
   assign w_hs  = bus.wvalid_i & bus.wready_o;
   assign ar_hs = bus.arvalid_i & bus.arready_o;

   // The write completes on the edge where the second of AW/W is accepted.
   assign wr_commit = ((wr_state_q == StIdle)   & aw_hs & w_hs) |
                      ((wr_state_q == StHaveAw) & w_hs) |
                      ((wr_state_q == StHaveW)  & aw_hs);

   // A channel captured earlier comes from its holding register, otherwise
   // straight from the bus.
   assign wr_addr = (wr_state_q == StHaveAw) ? awaddr_q : bus.awaddr_i;
   assign wr_data = (wr_state_q == StHaveW)  ? wdata_q  : bus.wdata_i;
   assign wr_strb = (wr_state_q == StHaveW)  ? wstrb_q  : bus.wstrb_i;
   assign wr_off  = wr_addr - BASE_ADDR;
   assign rd_off  = bus.araddr_i - BASE_ADDR;

   // Write decode: response code and which side effect the write carries.
   always_comb begin
      wr_resp  = RespOkay;
      do_print = 1'b0;
      do_exit  = 1'b0;
      do_pass  = 1'b0;
      do_fail  = 1'b0;
      if (wr_off >= ADDR_WIDTH'(16)) begin
         wr_resp = RespDecerr;
      end else begin
         unique case (wr_off[3:2])
            2'd0: begin
               do_print = wr_strb[0];
            end
            2'd1: begin
               if (wr_strb != 4'hF) begin
                  wr_resp = RespSlverr;
               end else begin
                  // Once an exit code is latched, later writes are accepted but ignored.
                  do_exit = ~exit_valid_q;
               end
            end
            2'd2: begin
               if (wr_strb != 4'hF) begin
                  wr_resp = RespSlverr;
               end else begin
                  do_pass = (wr_data == PassMagic);
                  do_fail = (wr_data == FailMagic);
               end
            end
            2'd3: begin
               wr_resp = RespSlverr;
            end
            default: wr_resp = RespSlverr;
         endcase
      end
   end

   // Read decode: data and response for the address presented on AR.
   always_comb begin
      rd_data = '0;
      rd_resp = RespSlverr;
      if (rd_off >= ADDR_WIDTH'(16)) begin
         rd_resp = RespDecerr;
      end else if (rd_off[3:2] == 2'd3) begin
`ifdef TB_CTRL_CYCLE_COUNTER_EN
         rd_data = cycle_q;
         rd_resp = RespOkay;
`else
         rd_resp = RespSlverr;
`endif
      end
   end

   // Write FSM with registered response and side-effect outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_state_q    <= StIdle;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         bvalid_q      <= 1'b0;
         bresp_q       <= RespOkay;
         print_valid_q <= 1'b0;
         print_wdata_q <= '0;
         exit_valid_q  <= 1'b0;
         exit_value_q  <= '0;
         passed_q      <= 1'b0;
         failed_q      <= 1'b0;
      end else begin
         print_valid_q <= 1'b0;
         case (wr_state_q)
            StIdle: begin
               if (aw_hs && w_hs) begin
                  wr_state_q <= StResp;
               end else if (aw_hs) begin
                  awaddr_q   <= bus.awaddr_i;
                  wr_state_q <= StHaveAw;
               end else if (w_hs) begin
                  wdata_q    <= bus.wdata_i;
                  wstrb_q    <= bus.wstrb_i;
                  wr_state_q <= StHaveW;
               end
            end
            StHaveAw: begin
               if (w_hs) wr_state_q <= StResp;
            end
            StHaveW: begin
               if (aw_hs) wr_state_q <= StResp;
            end
            StResp: begin
               if (bus.bready_i) begin
                  wr_state_q <= StIdle;
                  bvalid_q   <= 1'b0;
               end
            end
            default: wr_state_q <= StIdle;
         endcase

         if (wr_commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp;
            if (do_print) begin
               print_valid_q <= 1'b1;
               print_wdata_q <= wr_data;
            end
            if (do_exit) begin
               exit_valid_q <= 1'b1;
               exit_value_q <= wr_data;
            end
            if (do_pass) passed_q <= 1'b1;
            if (do_fail) failed_q <= 1'b1;
         end
      end
   end

   // Read FSM: one outstanding read, response held until RREADY.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_state_q <= RdIdle;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RespOkay;
      end else begin
         case (rd_state_q)
            RdIdle: begin
               if (ar_hs) begin
                  rd_state_q <= RdResp;
                  rvalid_q   <= 1'b1;
                  rdata_q    <= rd_data;
                  rresp_q    <= rd_resp;
               end
            end
            RdResp: begin
               if (bus.rready_i) begin
                  rd_state_q <= RdIdle;
                  rvalid_q   <= 1'b0;
               end
            end
            default: rd_state_q <= RdIdle;
         endcase
      end
   end

   assign bus.bvalid_o    = bvalid_q;
   assign bus.bresp_o     = bresp_q;
   assign bus.rvalid_o    = rvalid_q;
   assign bus.rdata_o     = rdata_q;
   assign bus.rresp_o     = rresp_q;

   assign print_valid_o  = print_valid_q;
   assign print_wdata_o  = print_wdata_q;
   assign exit_valid_o   = exit_valid_q;
   assign exit_value_o   = exit_value_q;
   assign tests_passed_o = passed_q;
   assign tests_failed_o = failed_q;

endmodule
